// File: rtl/fft_frame_feeder.sv
// Frames a free-running complex sample stream into N-sample Avalon-ST packets for
// the FFT sink port, buffering through a FWFT FIFO whose head sits in an output register.
module fft_frame_feeder #(
  parameter int N      = 64,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              in_sym_start,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  input  logic              inverse_cfg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [1:0]        out_error,
  output logic              out_inverse,
  output logic              overflow,
  output logic              dbg_state
);

  localparam int EW = 2*DATA_W + 5;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(N);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(N-1);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  // Handshake: a pop happens on any edge where out_valid & out_ready; out_* then
  // hold their value whenever out_valid=1 & out_ready=0. Upstream has no backpressure.

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            inv_lat;
  logic            pending_err;

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     mem_cnt;

  logic            pop;
  logic            load;
  logic            full;
  logic [AW:0]     occupancy;
  logic            push_req;
  logic            push_ok;
  logic            p_sop;
  logic            p_eop;
  logic [1:0]      p_err;
  logic            p_inv;
  logic [EW-1:0]   push_entry;

  assign dbg_state = (state == FILL);

  // Occupancy counts the output register too, so DEPTH is the total sample capacity.
  assign occupancy = mem_cnt + {{AW{1'b0}}, out_valid};
  assign full      = (occupancy == DEPTH_C);
  assign pop       = out_valid & out_ready;
  assign load      = (~out_valid | out_ready) & (mem_cnt != '0);

  always_comb begin
    push_req = 1'b0;
    p_sop    = 1'b0;
    p_eop    = 1'b0;
    p_err    = 2'b00;
    p_inv    = inv_lat;
    if (in_valid) begin
      if (in_sym_start) begin
        // A start while still in FILL abandons the frame, so this sop carries the error.
        push_req = 1'b1;
        p_sop    = 1'b1;
        p_inv    = inverse_cfg;
        p_err    = ((state == FILL) || pending_err) ? 2'b10 : 2'b00;
      end else if (state == FILL) begin
        push_req = 1'b1;
        p_eop    = (cnt == LAST_C);
      end
    end
    push_ok    = push_req & (~full | pop);
    push_entry = {in_real, in_imag, p_sop, p_eop, p_err, p_inv};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      inv_lat     <= 1'b0;
      pending_err <= 1'b0;
      overflow    <= 1'b0;
    end else if (push_req) begin
      if (!push_ok) begin
        overflow    <= 1'b1;
        pending_err <= 1'b1;
        state       <= IDLE;
        cnt         <= '0;
      end else if (p_sop) begin
        state       <= FILL;
        cnt         <= CW'(1);
        inv_lat     <= inverse_cfg;
        pending_err <= 1'b0;
      end else if (p_eop) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_cnt     <= '0;
      out_valid   <= 1'b0;
      out_real    <= '0;
      out_imag    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_error   <= 2'b00;
      out_inverse <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (load)    rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, load})
        2'b10:   mem_cnt <= mem_cnt + (AW+1)'(1);
        2'b01:   mem_cnt <= mem_cnt - (AW+1)'(1);
        default: mem_cnt <= mem_cnt;
      endcase
      // The output register only refills when empty or consumed, giving the hold rule.
      if (load) begin
        out_valid <= 1'b1;
        {out_real, out_imag, out_sop, out_eop, out_error, out_inverse} <= mem[rd_ptr];
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder: directed framing scenarios plus random traffic, all
// checked against a queue-based occupancy/framing model of the packetiser.
module tb_fft_frame_feeder;

  localparam int N     = 8;
  localparam int DW    = 12;
  localparam int DEPTH = 16;
  localparam int EW    = 2*DW + 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sym_start = 1'b0;
  logic [DW-1:0] in_real = '0;
  logic [DW-1:0] in_imag = '0;
  logic          inverse_cfg = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic          out_sop;
  logic          out_eop;
  logic [DW-1:0] out_real;
  logic [DW-1:0] out_imag;
  logic [1:0]    out_error;
  logic          out_inverse;
  logic          overflow;
  logic          dbg_state;
  logic [EW-1:0] dut_entry;

  always #5 clk = ~clk;

  fft_frame_feeder #(.N(N), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sym_start(in_sym_start),
    .in_real(in_real), .in_imag(in_imag), .inverse_cfg(inverse_cfg),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .out_real(out_real), .out_imag(out_imag), .out_error(out_error),
    .out_inverse(out_inverse), .overflow(overflow), .dbg_state(dbg_state)
  );

  assign dut_entry = {out_real, out_imag, out_sop, out_eop, out_error, out_inverse};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  // Model: exp_q holds every accepted sample not yet consumed, tag_q the edge it was
  // stored on. The head is visible once it has sat in the buffer for a full cycle.
  logic [EW-1:0] exp_q[$];
  int            tag_q[$];
  logic [EW-1:0] log_q[$];
  int            cyc = 0;
  bit            m_fill = 0;
  bit            m_pend = 0;
  bit            m_ovf = 0;
  bit            m_inv = 0;
  int            m_pos = 0;

  always @(negedge clk) begin : model
    logic       exp_valid;
    logic       pop;
    logic       accept;
    logic       req;
    logic       sop;
    logic       eop;
    logic [1:0] err;
    logic       inv;
    if (!reset_n) begin
      exp_q.delete();
      tag_q.delete();
      m_fill = 0; m_pend = 0; m_ovf = 0; m_inv = 0; m_pos = 0;
      check("reset_outputs", {out_valid, overflow, dbg_state, dut_entry}, '0);
    end else begin
      exp_valid = (exp_q.size() > 0) && (tag_q[0] < cyc);
      check("out_valid", out_valid, exp_valid);
      if (exp_valid) check("out_entry", dut_entry, exp_q[0]);
      check("overflow", overflow, m_ovf);
      check("in_frame", dbg_state, m_fill);
      if (out_valid && out_ready) log_q.push_back(dut_entry);

      pop    = exp_valid && out_ready;
      accept = (exp_q.size() < DEPTH) || pop;
      req = 0; sop = 0; eop = 0; err = 2'b00; inv = m_inv;
      if (in_valid) begin
        if (in_sym_start) begin
          req = 1; sop = 1; inv = inverse_cfg;
          err = (m_fill || m_pend) ? 2'b10 : 2'b00;
        end else if (m_fill) begin
          req = 1; eop = (m_pos == N-1);
        end
      end
      if (pop) begin
        void'(exp_q.pop_front());
        void'(tag_q.pop_front());
      end
      if (req) begin
        if (accept) begin
          exp_q.push_back({in_real, in_imag, sop, eop, err, inv});
          tag_q.push_back(cyc + 1);
          if (sop) begin
            m_fill = 1; m_pos = 1; m_inv = inverse_cfg; m_pend = 0;
          end else if (eop) begin
            m_fill = 0;
          end else begin
            m_pos++;
          end
        end else begin
          m_ovf = 1; m_pend = 1; m_fill = 0;
        end
      end
    end
    cyc++;
  end

  task automatic send(input logic ss, input logic [DW-1:0] d, input logic inv);
    in_valid = 1'b1;
    in_sym_start = ss;
    in_real = d;
    in_imag = d ^ 12'h5a5;
    inverse_cfg = inv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sym_start = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sym_start = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_log(input int idx, input logic [DW-1:0] re, input logic sop,
                           input logic eop, input logic [1:0] err, input logic inv);
    logic [EW-1:0] e;
    e = {re, re ^ 12'h5a5, sop, eop, err, inv};
    if (idx < log_q.size()) check($sformatf("log[%0d]", idx), log_q[idx], e);
    else check($sformatf("log[%0d]_missing", idx), 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single ramp packet with one-cycle latency.
    out_ready = 1'b1;
    log_q.delete();
    send(1, 0, 0);
    check("latency_not_yet", out_valid, 0);
    send(0, 1, 0);
    check("latency_valid", out_valid, 1);
    for (int i = 2; i < 8; i++) send(0, DW'(i), 0);
    idle(5);
    check("ramp_count", log_q.size(), 8);
    for (int i = 0; i < 8; i++) check_log(i, DW'(i), i == 0, i == 7, 2'b00, 0);

    // Back-to-back frames under toggling ready.
    log_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      out_ready = ~out_ready;
      send(i % 8 == 0, DW'(i), 0);
    end
    for (int i = 0; i < 40; i++) begin
      out_ready = ~out_ready;
      idle(1);
    end
    out_ready = 1'b1;
    idle(2);
    check("b2b_count", log_q.size(), 16);
    for (int i = 0; i < 16; i++) check_log(i, DW'(i), i % 8 == 0, i % 8 == 7, 2'b00, 0);

    // Early restart at sample 5.
    log_q.delete();
    for (int i = 0; i < 13; i++) send(i == 0 || i == 5, DW'(i), 0);
    idle(5);
    check("restart_count", log_q.size(), 13);
    for (int i = 0; i < 5; i++) check_log(i, DW'(i), i == 0, 0, 2'b00, 0);
    for (int i = 5; i < 13; i++) check_log(i, DW'(i), i == 5, i == 12, (i == 5) ? 2'b10 : 2'b00, 0);

    // Overflow while the sink stalls.
    log_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) send(i % 8 == 0, DW'(i), 0);
    idle(2);
    check("ovf_sticky", overflow, 1);
    check("ovf_idle", dbg_state, 0);
    check("ovf_hold_valid", out_valid, 1);
    check("ovf_hold_data", out_real, 0);
    out_ready = 1'b1;
    idle(20);
    for (int k = 0; k < 8; k++) send(k == 0, DW'(100 + k), 0);
    idle(5);
    check("ovf_count", log_q.size(), 24);
    for (int i = 0; i < 16; i++) check_log(i, DW'(i), i % 8 == 0, i % 8 == 7, 2'b00, 0);
    for (int k = 0; k < 8; k++) check_log(16 + k, DW'(100 + k), k == 0, k == 7, (k == 0) ? 2'b10 : 2'b00, 0);
    check("ovf_still_set", overflow, 1);

    // Inverse flag latched at sop.
    log_q.delete();
    for (int i = 0; i < 8; i++) send(i == 0, DW'(200 + i), i < 3);
    for (int i = 0; i < 8; i++) send(i == 0, DW'(210 + i), 0);
    idle(5);
    for (int i = 0; i < 8; i++) check_log(i, DW'(200 + i), i == 0, i == 7, 2'b00, 1);
    for (int i = 0; i < 8; i++) check_log(8 + i, DW'(210 + i), i == 0, i == 7, 2'b00, 0);

    // Asynchronous reset mid-frame.
    out_ready = 1'b0;
    send(1, 50, 0);
    send(0, 51, 0);
    send(0, 52, 0);
    reset_n = 1'b0;
    #1;
    check("rst_valid_now", out_valid, 0);
    check("rst_overflow_now", overflow, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    log_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(0, DW'(60 + i), 0);
    idle(3);
    check("rst_ignore_valid", out_valid, 0);
    check("rst_ignore_count", log_q.size(), 0);
    for (int i = 0; i < 8; i++) send(i == 0, DW'(70 + i), 0);
    idle(5);
    for (int i = 0; i < 8; i++) check_log(i, DW'(70 + i), i == 0, i == 7, 2'b00, 0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      out_ready    = ($urandom_range(0, 9) < 6);
      in_valid     = ($urandom_range(0, 9) < 7);
      in_sym_start = ($urandom_range(0, 11) == 0);
      in_real      = DW'($urandom);
      in_imag      = DW'($urandom);
      inverse_cfg  = DW'($urandom) == 0 ? 1'b0 : 1'($urandom_range(0, 1));
      if (c == 1500) reset_n = 1'b0;
      if (c == 1502) reset_n = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    idle(40);
    check("final_drained", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
